// File: rtl/reg_scoreboard_if.sv
// Issue / long-done / write-back bundle between ID, WB and the GPR scoreboard.
// master drives the events; slave (the scoreboard) answers with stall/fire/pending.
interface reg_scoreboard_if #(
    parameter int unsigned AW = 5
);
    logic          issue_valid;
    logic          issue_re1;
    logic [AW-1:0] issue_raddr1;
    logic          issue_re2;
    logic [AW-1:0] issue_raddr2;
    logic          issue_we;
    logic [AW-1:0] issue_waddr;
    logic          issue_long;
    logic          long_done;
    logic [AW-1:0] long_done_addr;
    logic          wb_we;
    logic [AW-1:0] wb_waddr;
    logic          stall;
    logic          issue_fire;
    logic          pending_any;

    modport master (
        output issue_valid, issue_re1, issue_raddr1, issue_re2, issue_raddr2,
        output issue_we, issue_waddr, issue_long, long_done, long_done_addr,
        output wb_we, wb_waddr,
        input  stall, issue_fire, pending_any
    );

    modport slave (
        input  issue_valid, issue_re1, issue_raddr1, issue_re2, issue_raddr2,
        input  issue_we, issue_waddr, issue_long, long_done, long_done_addr,
        input  wb_we, wb_waddr,
        output stall, issue_fire, pending_any
    );
endinterface

// File: rtl/reg_scoreboard.sv
// GPR write scoreboard: counts in-flight writers per register and stalls ID while a
// source operand waits on a long-latency producer that forwarding cannot yet supply.
module reg_scoreboard #(
    parameter int unsigned NREG = 32,
    parameter int unsigned CNTW = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    reg_scoreboard_if.slave  sb
);
    localparam int unsigned AW = 5;

    logic [CNTW-1:0] cnt_q [NREG];
    logic [CNTW-1:0] cnt_d [NREG];
    logic [NREG-1:0] lng_q, lng_d;
    logic            pending_q, pending_d;

    logic            hz1, hz2, sat, stall, fire;
    logic [NREG-1:0] iss_hit, ret_hit, done_hit;

    always_comb begin
        hz1   = sb.issue_re1 && (sb.issue_raddr1 != '0) && lng_q[sb.issue_raddr1];
        hz2   = sb.issue_re2 && (sb.issue_raddr2 != '0) && lng_q[sb.issue_raddr2];
        sat   = sb.issue_we && (sb.issue_waddr != '0) && (cnt_q[sb.issue_waddr] == '1);
        stall = sb.issue_valid && (hz1 || hz2 || sat);
        fire  = sb.issue_valid && !stall;
    end

    assign sb.stall       = stall;
    assign sb.issue_fire  = fire;
    assign sb.pending_any = pending_q;

    always_comb begin
        iss_hit   = '0;
        ret_hit   = '0;
        done_hit  = '0;
        cnt_d     = cnt_q;
        lng_d     = lng_q;
        pending_d = 1'b0;
        for (int unsigned r = 1; r < NREG; r++) begin
            iss_hit[r]  = fire && sb.issue_we && (sb.issue_waddr == AW'(r));
            ret_hit[r]  = sb.wb_we && (sb.wb_waddr == AW'(r)) && (cnt_q[r] != '0);
            done_hit[r] = sb.long_done && (sb.long_done_addr == AW'(r));
            if (iss_hit[r] && !ret_hit[r]) begin
                cnt_d[r] = cnt_q[r] + CNTW'(1);
            end else if (ret_hit[r] && !iss_hit[r]) begin
                cnt_d[r] = cnt_q[r] - CNTW'(1);
            end
            // The youngest writer decides forwardability, so a same-cycle issue overrides.
            if (iss_hit[r]) begin
                lng_d[r] = sb.issue_long;
            end else if (done_hit[r] || (ret_hit[r] && cnt_q[r] == CNTW'(1))) begin
                lng_d[r] = 1'b0;
            end
        end
        cnt_d[0] = '0;
        lng_d[0] = 1'b0;
        if (flush_i) begin
            cnt_d = '{default: '0};
            lng_d = '0;
        end
        for (int unsigned r = 1; r < NREG; r++) begin
            pending_d = pending_d | (cnt_d[r] != '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q     <= '{default: '0};
            lng_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            lng_q     <= lng_d;
            pending_q <= pending_d;
        end
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard with hand-computed expectations.
module tb_reg_scoreboard;
    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    logic flush_i = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    reg_scoreboard_if bus ();

    reg_scoreboard #(
        .NREG (32),
        .CNTW (2)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .sb      (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.issue_valid    = 1'b0;
        bus.issue_re1      = 1'b0;
        bus.issue_raddr1   = '0;
        bus.issue_re2      = 1'b0;
        bus.issue_raddr2   = '0;
        bus.issue_we       = 1'b0;
        bus.issue_waddr    = '0;
        bus.issue_long     = 1'b0;
        bus.long_done      = 1'b0;
        bus.long_done_addr = '0;
        bus.wb_we          = 1'b0;
        bus.wb_waddr       = '0;
        flush_i            = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue_wr(input logic [4:0] waddr, input logic lng);
        clear_inputs();
        bus.issue_valid = 1'b1;
        bus.issue_we    = 1'b1;
        bus.issue_waddr = waddr;
        bus.issue_long  = lng;
    endtask

    task automatic read1(input logic [4:0] raddr);
        clear_inputs();
        bus.issue_valid  = 1'b1;
        bus.issue_re1    = 1'b1;
        bus.issue_raddr1 = raddr;
    endtask

    initial begin
        // Reset held with a reader presented: nothing tracked, so it fires.
        clear_inputs();
        read1(5'd5);
        step();
        step();
        check_eq("rst_stall", bus.stall, 0);
        check_eq("rst_fire", bus.issue_fire, 1);
        check_eq("rst_pending", bus.pending_any, 0);
        rst_n_i = 1'b1;

        // Long producer on r8, dependent consumer.
        issue_wr(5'd8, 1'b1);
        #1 check_eq("long_prod_fire", bus.issue_fire, 1);
        step();
        read1(5'd8);
        #1 check_eq("raw_long_stall", bus.stall, 1);
        check_eq("raw_long_nofire", bus.issue_fire, 0);
        check_eq("pending_r8", bus.pending_any, 1);
        step();
        check_eq("raw_hold", bus.stall, 1);
        bus.long_done      = 1'b1;
        bus.long_done_addr = 5'd8;
        #1 check_eq("done_cycle_stall", bus.stall, 1);
        step();
        bus.long_done = 1'b0;
        #1 check_eq("after_done_stall", bus.stall, 0);
        check_eq("after_done_fire", bus.issue_fire, 1);
        step();
        clear_inputs();
        bus.wb_we    = 1'b1;
        bus.wb_waddr = 5'd8;
        #1 check_eq("pending_before_wb8", bus.pending_any, 1);
        step();
        clear_inputs();
        #1 check_eq("pending_after_wb8", bus.pending_any, 0);

        // Short producer on r3 never stalls a consumer.
        issue_wr(5'd3, 1'b0);
        step();
        read1(5'd3);
        bus.issue_re2    = 1'b1;
        bus.issue_raddr2 = 5'd3;
        #1 check_eq("short_no_stall", bus.stall, 0);
        step();
        clear_inputs();
        step();
        check_eq("short_pending", bus.pending_any, 1);
        bus.wb_we    = 1'b1;
        bus.wb_waddr = 5'd3;
        step();
        clear_inputs();
        check_eq("short_retired", bus.pending_any, 0);

        // Saturate r4 at three writers.
        for (int i = 0; i < 3; i++) begin
            issue_wr(5'd4, 1'b0);
            #1 check_eq("sat_fill_fire", bus.issue_fire, 1);
            step();
        end
        issue_wr(5'd4, 1'b0);
        bus.wb_we    = 1'b1;
        bus.wb_waddr = 5'd4;
        #1 check_eq("sat_stall", bus.stall, 1);
        check_eq("sat_nofire", bus.issue_fire, 0);
        step();
        bus.wb_we = 1'b0;
        #1 check_eq("sat_release_fire", bus.issue_fire, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            bus.wb_we    = 1'b1;
            bus.wb_waddr = 5'd4;
            step();
        end
        clear_inputs();
        check_eq("sat_drained", bus.pending_any, 0);
        // Retire with nothing in flight must not wrap the counter.
        bus.wb_we    = 1'b1;
        bus.wb_waddr = 5'd4;
        step();
        clear_inputs();
        step();
        check_eq("no_underflow", bus.pending_any, 0);

        // Same-cycle issue + retire on r9.
        issue_wr(5'd9, 1'b0);
        step();
        issue_wr(5'd9, 1'b1);
        bus.wb_we    = 1'b1;
        bus.wb_waddr = 5'd9;
        step();
        read1(5'd9);
        #1 check_eq("iss_ret_lng", bus.stall, 1);
        check_eq("iss_ret_pending", bus.pending_any, 1);
        clear_inputs();
        bus.wb_we    = 1'b1;
        bus.wb_waddr = 5'd9;
        step();
        read1(5'd9);
        #1 check_eq("cnt0_clears_lng", bus.stall, 0);
        check_eq("r9_pending", bus.pending_any, 0);

        // Register 0 is never tracked.
        issue_wr(5'd0, 1'b1);
        step();
        read1(5'd0);
        #1 check_eq("r0_no_stall", bus.stall, 0);
        check_eq("r0_no_pending", bus.pending_any, 0);

        // Issue + long_done on r11: issue wins; then retire + done both apply.
        issue_wr(5'd11, 1'b1);
        bus.long_done      = 1'b1;
        bus.long_done_addr = 5'd11;
        step();
        read1(5'd11);
        #1 check_eq("iss_done_wins", bus.stall, 1);
        clear_inputs();
        bus.long_done      = 1'b1;
        bus.long_done_addr = 5'd11;
        bus.wb_we          = 1'b1;
        bus.wb_waddr       = 5'd11;
        step();
        read1(5'd11);
        #1 check_eq("ret_done_stall", bus.stall, 0);
        check_eq("ret_done_pending", bus.pending_any, 0);

        // Flush with r6 long pending and a simultaneous r7 issue.
        issue_wr(5'd6, 1'b1);
        step();
        read1(5'd6);
        flush_i = 1'b1;
        #1 check_eq("flush_cycle_stall", bus.stall, 1);
        issue_wr(5'd7, 1'b1);
        flush_i = 1'b1;
        #1 check_eq("flush_cycle_fire", bus.issue_fire, 1);
        step();
        read1(5'd6);
        bus.issue_re2    = 1'b1;
        bus.issue_raddr2 = 5'd7;
        #1 check_eq("post_flush_stall", bus.stall, 0);
        check_eq("post_flush_pending", bus.pending_any, 0);

        // Asynchronous reset mid-cycle clears r10 without a clock edge.
        issue_wr(5'd10, 1'b1);
        step();
        read1(5'd10);
        #1 check_eq("pre_areset_stall", bus.stall, 1);
        check_eq("pre_areset_pending", bus.pending_any, 1);
        rst_n_i = 1'b0;
        #1 check_eq("areset_stall", bus.stall, 0);
        check_eq("areset_pending", bus.pending_any, 0);
        rst_n_i = 1'b1;
        clear_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
